// File: rtl/vote_collector_pkg.sv
// Shared constants and state encoding for the vote collector.
package vote_pkg;

    localparam int NUM_VOTERS = 4;
    localparam int TIMER_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vote_collector_rise_detect.sv
// Per-bit rising-edge detector: remembers last cycle's level and flags 0->1 transitions.
module rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // History tracks the input every cycle regardless of collector state
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/vote_collector.sv
// Collects one locked yes/no ballot per voter during a timed voting session.
module vote_collector
    import vote_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_VOTERS-1:0] vote_yes,
    input  logic [NUM_VOTERS-1:0] vote_no,
    output logic [NUM_VOTERS-1:0] ballot,
    output logic                  ballot_valid,
    output logic [NUM_VOTERS-1:0] voted,
    output logic                  busy,
    output logic                  timed_out
);

    localparam logic [NUM_VOTERS-1:0] ALL_VOTED = '1;

    state_t                  state;
    state_t                  state_next;
    logic [TIMER_W-1:0]      timer;
    logic [NUM_VOTERS-1:0]   yes_rise;
    logic [NUM_VOTERS-1:0]   no_rise;
    logic [NUM_VOTERS-1:0]   yes_lock;
    logic [NUM_VOTERS-1:0]   no_lock;
    logic [NUM_VOTERS-1:0]   voted_next;

    rise_detect #(.WIDTH(NUM_VOTERS)) u_yes_edge (
        .clk   (clk),
        .rst   (rst),
        .level (vote_yes),
        .rise  (yes_rise)
    );

    rise_detect #(.WIDTH(NUM_VOTERS)) u_no_edge (
        .clk   (clk),
        .rst   (rst),
        .level (vote_no),
        .rise  (no_rise)
    );

    // A voter locks only on an unambiguous press and only if not already locked
    assign yes_lock   = yes_rise & ~no_rise & ~voted;
    assign no_lock    = no_rise & ~yes_rise & ~voted;
    assign voted_next = voted | yes_lock | no_lock;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a completed set wins over a simultaneous timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = OPEN;
            OPEN: begin
                if (voted_next == ALL_VOTED)  state_next = DONE;
                else if (timer == '0)         state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded directly from the state register
    always_comb begin
        busy         = (state == OPEN);
        ballot_valid = (state == DONE);
    end

    // Session datapath: ballot, lock flags, countdown timer and timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ballot    <= '0;
            voted     <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ballot    <= '0;
                        voted     <= '0;
                        timed_out <= 1'b0;
                        timer     <= TIMEOUT_CYCLES - 16'd1;
                    end
                end
                OPEN: begin
                    // No-locks leave the bit at its cleared value of 0
                    ballot <= ballot | yes_lock;
                    voted  <= voted_next;
                    if (timer != '0) timer <= timer - 16'd1;
                    if (timer == '0 && voted_next != ALL_VOTED) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with an 8-cycle session timeout.
module tb_vote_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vote_yes;
    logic [3:0] vote_no;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic [3:0] voted;
    logic       busy;
    logic       timed_out;

    int total = 0;
    int bad   = 0;

    vote_collector #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vote_yes     (vote_yes),
        .vote_no      (vote_no),
        .ballot       (ballot),
        .ballot_valid (ballot_valid),
        .voted        (voted),
        .busy         (busy),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vote_yes = 4'b0000; vote_no = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ballot", ballot, 4'b0000);
        chk("rst_voted", voted, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_valid", {3'b0, ballot_valid}, 4'd0);
        chk("rst_timed_out", {3'b0, timed_out}, 4'd0);

        // Four voters on distinct cycles: yes, yes, no, no
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", {3'b0, busy}, 4'd1);
        vote_yes = 4'b0001; tick();
        chk("t1_voted_a", voted, 4'b0001);
        vote_yes = 4'b0011; tick();
        chk("t1_voted_b", voted, 4'b0011);
        vote_no = 4'b0100; tick();
        chk("t1_voted_c", voted, 4'b0111);
        chk("t1_no_valid_yet", {3'b0, ballot_valid}, 4'd0);
        vote_no = 4'b1100; tick();
        chk("t1_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t1_ballot", ballot, 4'b0011);
        chk("t1_timed_out", {3'b0, timed_out}, 4'd0);
        chk("t1_busy_done", {3'b0, busy}, 4'd0);
        tick();
        chk("t1_valid_pulse", {3'b0, ballot_valid}, 4'd0);
        chk("t1_ballot_hold", ballot, 4'b0011);
        vote_yes = 4'b0000; vote_no = 4'b0000; tick();

        // Only voter 3 votes; session closes 8 edges after entering OPEN
        start = 1'b1; tick(); start = 1'b0;
        vote_yes = 4'b1000; tick();
        vote_yes = 4'b0000;
        repeat (6) tick();
        chk("t2_still_open", {3'b0, busy}, 4'd1);
        tick();
        chk("t2_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t2_ballot", ballot, 4'b1000);
        chk("t2_voted", voted, 4'b1000);
        chk("t2_timed_out", {3'b0, timed_out}, 4'd1);
        tick();
        chk("t2_idle", {3'b0, busy}, 4'd0);
        chk("t2_timed_out_hold", {3'b0, timed_out}, 4'd1);

        // First lock wins; simultaneous yes+no is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_timed_out_clr", {3'b0, timed_out}, 4'd0);
        vote_yes = 4'b0001; tick();
        chk("t3_lock0", ballot, 4'b0001);
        vote_yes = 4'b0000; vote_no = 4'b0001; tick();
        chk("t3_no_ignored", ballot, 4'b0001);
        vote_yes = 4'b0011; vote_no = 4'b0010; tick();
        chk("t3_both_voted", voted, 4'b0001);
        chk("t3_both_ballot", ballot, 4'b0001);
        vote_yes = 4'b0000; vote_no = 4'b0000;
        repeat (4) tick();
        chk("t3_open", {3'b0, busy}, 4'd1);
        tick();
        chk("t3_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t3_ballot", ballot, 4'b0001);
        chk("t3_timed_out", {3'b0, timed_out}, 4'd1);
        tick();

        // Buttons held from before start never register
        vote_yes = 4'b1111; tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t4_no_locks", voted, 4'b0000);
        repeat (6) tick();
        chk("t4_open", {3'b0, busy}, 4'd1);
        tick();
        chk("t4_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t4_ballot", ballot, 4'b0000);
        chk("t4_timed_out", {3'b0, timed_out}, 4'd1);
        tick();
        vote_yes = 4'b0000; tick();

        // Reset mid-session aborts without a ballot_valid pulse
        start = 1'b1; tick(); start = 1'b0;
        vote_yes = 4'b0001; tick();
        vote_yes = 4'b0011; tick();
        chk("t5_two_locked", voted, 4'b0011);
        rst = 1'b1; vote_yes = 4'b0000; tick(); rst = 1'b0;
        chk("t5_rst_voted", voted, 4'b0000);
        chk("t5_rst_ballot", ballot, 4'b0000);
        chk("t5_rst_busy", {3'b0, busy}, 4'd0);
        chk("t5_rst_valid", {3'b0, ballot_valid}, 4'd0);
        tick();
        chk("t5_no_pulse", {3'b0, ballot_valid}, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_restart", {3'b0, busy}, 4'd1);
        vote_yes = 4'b1111; tick();
        chk("t5_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t5_ballot", ballot, 4'b1111);
        chk("t5_timed_out", {3'b0, timed_out}, 4'd0);
        tick();
        vote_yes = 4'b0000; tick();

        // Last vote lands on the timer=0 cycle; start during OPEN/DONE ignored
        start = 1'b1; tick();
        vote_yes = 4'b0001; tick(); start = 1'b0;
        chk("t6_start_ignored", {3'b0, busy}, 4'd1);
        chk("t6_lock0", voted, 4'b0001);
        vote_yes = 4'b0000; vote_no = 4'b0010; tick();
        vote_no = 4'b0110; tick();
        chk("t6_three", voted, 4'b0111);
        repeat (4) tick();
        chk("t6_open_last", {3'b0, busy}, 4'd1);
        vote_yes = 4'b1000; tick();
        chk("t6_valid", {3'b0, ballot_valid}, 4'd1);
        chk("t6_ballot", ballot, 4'b1001);
        chk("t6_timed_out", {3'b0, timed_out}, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_done_start_ign", {3'b0, busy}, 4'd0);
        tick();
        chk("t6_stay_idle", {3'b0, busy}, 4'd0);
        chk("t6_ballot_hold", ballot, 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
